// File: rtl/note_sequencer_if.sv
// Control, song-memory read and tone-output signals of the note sequencer.
// master = sequencer side, slave = host/memory/tone-generator side.
interface note_sequencer_if;
    logic [6:0]  key_note;
    logic        start;
    logic        stop;
    logic [1:0]  tempo_sel;
    logic [5:0]  rd_addr;
    logic [10:0] rd_data;
    logic [6:0]  note_out;
    logic        busy;
    logic        done;

    modport master (
        input  key_note, start, stop, tempo_sel, rd_data,
        output rd_addr, note_out, busy, done
    );

    modport slave (
        output key_note, start, stop, tempo_sel, rd_data,
        input  rd_addr, note_out, busy, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Song auto-player with manual keyboard pass-through while idle.
// Optional NOTE_SEQUENCER_KEY_OVERRIDE_EN lets a held key replace the song note during play.
module note_sequencer #(
    parameter int TICK_DIV = 100000,
    parameter int GAP_MS   = 20,
    parameter int SONG_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    note_sequencer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // 12 bits covers 15 beats of 250 ms; widen if the gap needs more
    localparam int MW = ($clog2(GAP_MS + 1) > 12) ? $clog2(GAP_MS + 1) : 12;

    state_t        state, state_nxt;
    logic [TW-1:0] tick;
    logic [MW-1:0] ms;
    logic [5:0]    addr;
    logic [1:0]    tempo_q;
    logic [6:0]    key_q;
    logic [6:0]    note_q;
    logic [3:0]    dur_q;
    logic [MW-1:0] beat_ms;
    logic [MW-1:0] play_ms;
    logic          tick_last, play_end, gap_end, busy_c;
    logic [6:0]    song_note, note_c;

    always_comb begin
        case (tempo_q)
            2'b00:   beat_ms = MW'(250);
            2'b01:   beat_ms = MW'(200);
            2'b10:   beat_ms = MW'(150);
            default: beat_ms = MW'(100);
        endcase
    end

    assign play_ms   = MW'(dur_q) * beat_ms;
    assign tick_last = (tick == TW'(TICK_DIV - 1));
    assign play_end  = tick_last && (ms == play_ms - MW'(1));
    assign gap_end   = tick_last && (ms == MW'(GAP_MS - 1));
    assign busy_c    = (state == FETCH) || (state == LOAD) ||
                       (state == PLAY)  || (state == GAP);
    assign song_note = (note_q > 7'd21) ? 7'd0 : note_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.stop) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = (bus.rd_data[3:0] == 4'd0) ? DONE : PLAY;
            PLAY:    if (play_end) state_nxt = GAP;
            GAP:     if (gap_end)
                         state_nxt = (addr == 6'(SONG_LEN - 1)) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (busy_c && bus.stop) state_nxt = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            ms      <= '0;
            addr    <= '0;
            tempo_q <= 2'b00;
            key_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            state <= state_nxt;
            key_q <= bus.key_note;
            if (state == IDLE && state_nxt == FETCH) tempo_q <= bus.tempo_sel;
            if (state == LOAD) {note_q, dur_q} <= bus.rd_data;
            if (state == GAP && state_nxt == FETCH) addr <= addr + 6'd1;
            else if (state == DONE)                 addr <= '0;
            // counters restart on every state change, so PLAY and GAP always begin at zero
            if (state_nxt != state || !(state == PLAY || state == GAP)) begin
                tick <= '0;
                ms   <= '0;
            end else if (tick_last) begin
                tick <= '0;
                ms   <= ms + MW'(1);
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    always_comb begin
        note_c = 7'd0;
        case (state)
            IDLE:    note_c = key_q;
            PLAY:    note_c = song_note;
            default: note_c = 7'd0;
        endcase
`ifdef NOTE_SEQUENCER_KEY_OVERRIDE_EN
        if ((state == PLAY || state == GAP) && key_q != 7'd0) note_c = key_q;
`endif
    end

    assign bus.note_out = note_c;
    assign bus.rd_addr  = addr;
    assign bus.busy     = busy_c;
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed cases plus random songs checked against
// a per-cycle expected note stream derived from the song contents.
module tb_note_sequencer;
    localparam int TICK_DIV = 4;
    localparam int GAP_MS   = 2;
    localparam int SONG_LEN = 4;

    logic clk = 1'b0;
    logic rst;

    note_sequencer_if bus();

    note_sequencer #(.TICK_DIV(TICK_DIV), .GAP_MS(GAP_MS), .SONG_LEN(SONG_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [10:0] mem [SONG_LEN];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[1:0]];

    typedef struct {
        logic [6:0] note;
        bit         ovr;
        bit         fetch;
        int         addr;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        ncmp++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int beat(input logic [1:0] t);
        case (t)
            2'd0:    return 250;
            2'd1:    return 200;
            2'd2:    return 150;
            default: return 100;
        endcase
    endfunction

    task automatic push(input int note, input bit ovr, input bit fetch, input int addr);
        exp_t e;
        e.note  = 7'(note);
        e.ovr   = ovr;
        e.fetch = fetch;
        e.addr  = addr;
        q.push_back(e);
    endtask

    // one entry per busy cycle: fetch, load, note for the beat time, then the silent gap
    task automatic build(input logic [1:0] tsel);
        q.delete();
        for (int a = 0; a < SONG_LEN; a++) begin
            int d;
            int n;
            push(0, 1'b0, 1'b1, a);
            push(0, 1'b0, 1'b0, a);
            d = int'(mem[a][3:0]);
            if (d == 0) break;
            n = int'(mem[a][10:4]);
            if (n > 21) n = 0;
            repeat (d * beat(tsel) * TICK_DIV) push(n, 1'b1, 1'b0, a);
            repeat (GAP_MS * TICK_DIV) push(0, 1'b1, 1'b0, a);
        end
    endtask

    task automatic run_song(input logic [1:0] tsel, input bit noisy);
        logic [6:0] kprev;
        logic [6:0] want;
        build(tsel);
        bus.tempo_sel = tsel;
        bus.key_note  = '0;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        kprev = '0;
        foreach (q[i]) begin
            want = q[i].note;
`ifdef NOTE_SEQUENCER_KEY_OVERRIDE_EN
            if (q[i].ovr && kprev != 7'd0) want = kprev;
`endif
            check("busy", 32'(bus.busy), 32'd1);
            check("note_out", 32'(bus.note_out), 32'(want));
            if (q[i].fetch) check("rd_addr", 32'(bus.rd_addr), 32'(q[i].addr));
            if (noisy) begin
                bus.key_note  = (i < q.size() - 1) ? 7'($urandom_range(0, 21)) : 7'd0;
                bus.tempo_sel = 2'($urandom);
                bus.start     = ($urandom_range(0, 7) == 0);
            end
            kprev = bus.key_note;
            step();
        end
        bus.start    = 1'b0;
        bus.key_note = '0;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("done_note", 32'(bus.note_out), 32'd0);
        step();
        check("done_clear", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_addr", 32'(bus.rd_addr), 32'd0);
    endtask

    initial begin
        bus.key_note  = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.tempo_sel = 2'b00;
        rst = 1'b1;
        for (int i = 0; i < SONG_LEN; i++) mem[i] = '0;
        step();
        step();
        check("rst_note", 32'(bus.note_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", 32'(bus.rd_addr), 32'd0);

        rst = 1'b0;
        bus.key_note = 7'd5;
        step();
        check("key_idle", 32'(bus.note_out), 32'd5);
        check("key_busy", 32'(bus.busy), 32'd0);
        bus.key_note = '0;
        step();

        // short song ended by a zero-duration entry
        mem[0] = {7'd8, 4'd1};
        mem[1] = '0;
        run_song(2'b11, 1'b0);

        // full memory, no wrap after the last entry
        for (int a = 0; a < SONG_LEN; a++) mem[a] = {7'(a + 1), 4'd1};
        run_song(2'b11, 1'b0);

        // out-of-range note plays as a rest
        mem[0] = {7'd30, 4'd1};
        mem[1] = '0;
        run_song(2'b11, 1'b0);

        // stop part way through a note
        mem[0] = {7'd9, 4'd2};
        mem[1] = {7'd3, 4'd1};
        bus.tempo_sel = 2'b00;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        repeat (9) step();
        check("stop_pre_note", 32'(bus.note_out), 32'd9);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("stop_done", 32'(bus.done), 32'd1);
        check("stop_note", 32'(bus.note_out), 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        step();
        check("stop_done_clr", 32'(bus.done), 32'd0);
        check("stop_idle", 32'(bus.busy), 32'd0);

        // simultaneous start and stop while idle
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss_busy", 32'(bus.busy), 32'd0);
        step();
        check("ss_busy2", 32'(bus.busy), 32'd0);
        check("ss_done", 32'(bus.done), 32'd0);

        // reset in the middle of a note
        mem[0] = {7'd7, 4'd1};
        bus.tempo_sel = 2'b11;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        check("rmid_pre_note", 32'(bus.note_out), 32'd7);
        rst = 1'b1;
        step();
        check("rmid_note", 32'(bus.note_out), 32'd0);
        check("rmid_busy", 32'(bus.busy), 32'd0);
        check("rmid_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        step();
        check("rmid_done2", 32'(bus.done), 32'd0);
        check("rmid_idle", 32'(bus.busy), 32'd0);

        // random songs with noise on key, tempo and start while busy
        repeat (4) begin
            logic [1:0] tsel;
            for (int a = 0; a < SONG_LEN; a++) begin
                int d;
                d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2));
                mem[a] = {7'($urandom_range(0, 31)), 4'(d)};
            end
            tsel = 2'($urandom);
            run_song(tsel, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk cycles per 1 ms tick.
REQ-002 Parameter GAP_MS, default 20, silent gap in ms after every song note.
REQ-003 Parameter SONG_LEN, default 64, song memory depth in entries.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 key_note  in  7  manual keyboard note code; 0 = silence, 1..21 = C3..B5.
REQ-007 start  in  1  one-cycle request to begin auto-play from address 0.
REQ-008 stop  in  1  one-cycle request to abort auto-play.
REQ-009 tempo_sel  in  2  beat length select: 00=250 ms, 01=200 ms, 10=150 ms, 11=100 ms.
REQ-010 rd_addr  out  6  song memory address.
REQ-011 rd_data  in  11  song entry {note[10:4], dur[3:0]}, valid one cycle after rd_addr.
REQ-012 note_out  out  7  note code driven to the tone generator.
REQ-013 busy  out  1  high while auto-play is active.
REQ-014 done  out  1  one-cycle pulse when auto-play ends, normally or by stop.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, LOAD, PLAY, GAP, DONE.
REQ-016 IDLE: note_out SHALL equal key_note registered (1-cycle latency); busy=0; start with stop=0 SHALL go to FETCH and latch tempo_sel.
REQ-017 FETCH: rd_addr SHALL present the current address for one cycle, then go to LOAD.
REQ-018 LOAD: rd_data SHALL be captured; dur=0 SHALL mean end-of-song and go to DONE; otherwise go to PLAY.
REQ-019 PLAY: note_out SHALL be the captured note for exactly dur x beat_ms x TICK_DIV cycles, then go to GAP.
REQ-020 Captured note codes above 21 SHALL be played as 0 (rest) with normal duration.
REQ-021 GAP: note_out SHALL be 0 for exactly GAP_MS x TICK_DIV cycles; address SHALL then increment and go to FETCH.
REQ-022 After the entry at address SHALL SONG_LEN-1 completes its GAP, the FSM SHALL go to DONE without wrapping.
REQ-023 DONE: done SHALL be 1 for one cycle, note_out 0, address cleared, then IDLE.
REQ-024 busy SHALL be 1 in FETCH, LOAD, PLAY, GAP; 0 in IDLE and DONE.
REQ-025 The tick and ms counters SHALL clear on every entry to PLAY and GAP.
REQ-026 stop in any busy state SHALL go to DONE on the next edge; stop and start in the same cycle: stop wins, start ignored.
REQ-027 start while busy SHALL be ignored; tempo_sel changes while busy SHALL have no effect.
REQ-028 Arithmetic: duration counters SHALL be wide enough for 15 x 250 x TICK_DIV without overflow.

Reset
REQ-029 rst SHALL force IDLE, note_out=0, rd_addr=0, busy=0, done=0, all counters 0, latched tempo=00.
REQ-030 rst asserted mid-play SHALL silence note_out on the next edge and produce no done pulse.

Configuration
REQ-031 Macro NOTE_SEQUENCER_KEY_OVERRIDE_EN: when defined, a nonzero key_note during PLAY or GAP SHALL drive note_out instead of the song note while song timing continues unchanged; when undefined, key_note SHALL be ignored while busy.

Verification (TICK_DIV=4, GAP_MS=2, SONG_LEN=4)
REQ-032 rst then key_note=5 in IDLE -> note_out=5 one cycle later, busy=0.
REQ-033 memory {note 8 dur 1, note 0 dur 0}, tempo 11, start -> note_out=8 for 400 cycles, 0 for 8 cycles, then done pulse, busy falls.
REQ-034 four entries all dur 1 notes 1..4 -> all played in order, done after address 3 gap, rd_addr never exceeds 3.
REQ-035 stop asserted 10 cycles into PLAY -> done on next edge, note_out=0; start+stop same cycle in IDLE -> stays IDLE.
REQ-036 entry note 30 dur 1 -> note_out=0 for full duration; with KEY_OVERRIDE_EN, key_note=12 during PLAY -> note_out=12, total PLAY length unchanged.
REQ-037 rst mid-PLAY -> note_out=0 and busy=0 next edge, done stays 0.
